// File: rtl/instr_fetch_unit.sv
`default_nettype none
// instr_fetch_unit: owns the PC and fetches one word per step over a req/ack port.
// Macro FETCH_ALIGN_CHECK_EN: a misaligned pc_new faults (code 2'b10) instead of being truncated.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [15:0] TIMEOUT  = 16'd64
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        step,
  input  logic [31:0] pc_new,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [1:0]  CODE_NONE     = 2'b00;
  localparam logic [1:0]  CODE_TIMEOUT  = 2'b01;
  localparam logic [1:0]  CODE_MISALIGN = 2'b10;
  localparam logic [31:0] ALIGN_MASK    = 32'hFFFF_FFFC;
  // With the watchdog disabled the counter simply parks at its maximum.
  localparam logic [15:0] WD_LIMIT      = (TIMEOUT == 16'd0) ? 16'hFFFF : TIMEOUT - 16'd1;

  state_t      state;
  logic [15:0] watchdog;
  logic        timeout_hit;
  logic        misaligned;

  assign timeout_hit = (TIMEOUT != 16'd0) && (watchdog == WD_LIMIT);
  assign imem_addr   = pc;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = (pc_new[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      fault_code  <= CODE_NONE;
      retired     <= '0;
      watchdog    <= '0;
      imem_req    <= 1'b1;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          // An ack in the timeout cycle still completes the fetch.
          if (imem_ack) begin
            instr       <= imem_rdata;
            watchdog    <= '0;
            state       <= HOLD;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end else if (timeout_hit) begin
            fault_code  <= CODE_TIMEOUT;
            state       <= FAULT;
            imem_req    <= 1'b0;
            fault       <= 1'b1;
          end else if (watchdog != WD_LIMIT) begin
            watchdog    <= watchdog + 16'd1;
          end
        end
        HOLD: begin
          if (step) begin
            instr_valid <= 1'b0;
            if (misaligned) begin
              fault_code <= CODE_MISALIGN;
              state      <= FAULT;
              fault      <= 1'b1;
            end else begin
              pc       <= pc_new & ALIGN_MASK;
              retired  <= retired + 32'd1;
              state    <= FETCH;
              imem_req <= 1'b1;
            end
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state       <= FAULT;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          fault       <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// tb_instr_fetch_unit: transaction-level reference model with randomized memory latency and steps.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam logic [15:0] TIMEOUT  = 16'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        step = 1'b0;
  logic [31:0] pc_new = '0;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] retired;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc), .instr(instr), .instr_valid(instr_valid),
    .step(step), .pc_new(pc_new),
    .fault(fault), .fault_code(fault_code), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural expectations
  logic [31:0] m_pc, m_instr, m_retired;
  logic [1:0]  m_code;
  bit          m_faulted;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // exp_req < 0 skips the request check (reset window)
  task automatic check_state(input string tag, input int exp_req, input bit exp_valid);
    if (exp_req >= 0) check_eq({tag, ".imem_req"}, 32'(imem_req), 32'(exp_req));
    check_eq({tag, ".pc"},          pc,                  m_pc);
    check_eq({tag, ".imem_addr"},   imem_addr,           m_pc);
    check_eq({tag, ".instr"},       instr,               m_instr);
    check_eq({tag, ".instr_valid"}, 32'(instr_valid),    32'(exp_valid));
    check_eq({tag, ".fault"},       32'(fault),          32'(m_faulted));
    check_eq({tag, ".fault_code"},  32'(fault_code),     32'(m_code));
    check_eq({tag, ".retired"},     retired,             m_retired);
  endtask

  // Called at a falling edge; reset is asynchronous so it is checked without a clock.
  task automatic do_reset();
    reset = 1'b1; step = 1'b0; imem_ack = 1'b0;
    m_pc = RESET_PC; m_instr = '0; m_retired = '0; m_code = 2'b00; m_faulted = 1'b0;
    #1 check_state("reset", -1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Memory answers after lat wait cycles; stray steps during the fetch must be ignored.
  task automatic fetch_txn(input int lat, input logic [31:0] word);
    for (int c = 0; c <= lat; c++) begin
      check_state("fetch", 1, 1'b0);
      imem_ack   = (c == lat);
      imem_rdata = (c == lat) ? word : $urandom;
      step       = 1'($urandom_range(0, 1));
      pc_new     = $urandom;
      @(negedge clk);
    end
    imem_ack = 1'b0; step = 1'b0;
    m_instr = word;
    check_state("hold", 0, 1'b1);
  endtask

  task automatic hold_and_step(input int h, input logic [31:0] npc);
    for (int c = 0; c < h; c++) begin
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      step       = 1'b0;
      @(negedge clk);
      check_state("hold_wait", 0, 1'b1);
    end
    imem_ack = 1'b0; step = 1'b1; pc_new = npc;
    @(negedge clk);
    step = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    if (npc[1:0] != 2'b00) begin
      m_faulted = 1'b1; m_code = 2'b10;
      check_state("misalign", 0, 1'b0);
      return;
    end
`endif
    m_pc = {npc[31:2], 2'b00};
    m_retired = m_retired + 32'd1;
  endtask

  task automatic frozen(input int n);
    for (int c = 0; c < n; c++) begin
      step = 1'b1; pc_new = $urandom; imem_ack = 1'b1; imem_rdata = $urandom;
      @(negedge clk);
      check_state("frozen", 0, 1'b0);
    end
    step = 1'b0; imem_ack = 1'b0;
  endtask

  task automatic timeout_txn();
    for (int c = 0; c < int'(TIMEOUT); c++) begin
      check_state("wait_ack", 1, 1'b0);
      imem_ack = 1'b0;
      @(negedge clk);
    end
    m_faulted = 1'b1; m_code = 2'b01;
    check_state("timeout", 0, 1'b0);
    frozen(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] npc;
    @(negedge clk);

    // Directed: zero-wait fetch, 3-wait fetch on the timeout boundary, misaligned step.
    do_reset();
    fetch_txn(0, 32'h2008_0005);
    hold_and_step(1, 32'h0000_0104);
    fetch_txn(3, $urandom);
    hold_and_step(0, 32'h0000_0106);
    if (m_faulted) frozen(2);
    else fetch_txn(1, $urandom);

    // Memory never answers.
    do_reset();
    timeout_txn();

    // Reset while a request at 0x200 is outstanding.
    do_reset();
    fetch_txn(0, $urandom);
    hold_and_step(0, 32'h0000_0200);
    check_state("pending", 1, 1'b0);
    @(negedge clk);
    do_reset();
    fetch_txn(2, $urandom);

    // Retired-counter wrap.
    do_reset();
    fetch_txn(0, $urandom);
    force dut.retired = 32'hFFFF_FFFF;
    #1 release dut.retired;
    m_retired = 32'hFFFF_FFFF;
    check_state("preload", 0, 1'b1);
    @(negedge clk);
    hold_and_step(0, 32'h0000_0108);
    fetch_txn(0, $urandom);

    // Randomized traffic.
    hold_and_step(0, 32'h0000_0010);
    for (int i = 0; i < 60; i++) begin
      if (m_faulted) begin
        frozen(1);
        do_reset();
      end
      if ($urandom_range(0, 9) == 0) begin
        timeout_txn();
        do_reset();
      end
      fetch_txn($urandom_range(0, 3), $urandom);
      npc = $urandom;
      if ($urandom_range(0, 4) != 0) npc[1:0] = 2'b00;
      hold_and_step($urandom_range(0, 2), npc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
